// File: rtl/fpu_arb_pkg.sv
// Shared constants and payload types for the fpu_arbiter slice.
// Holds the FSM encodings, opcode values, packed-word field slices and watchdog defaults.
package fpu_arb_pkg;

    localparam int unsigned WORD_W = 23;
    localparam int unsigned S_BIT  = 22;
    localparam int unsigned E_HI   = 21;
    localparam int unsigned E_LO   = 15;
    localparam int unsigned M_HI   = 14;
    localparam int unsigned M_LO   = 0;

    localparam int unsigned DEF_TIMEOUT_CYCLES = 32;
    localparam int unsigned TMO_W              = 6;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ISSUE     = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_RESP      = 3'd4;

    typedef struct packed {
        logic              op;
        logic [WORD_W-1:0] a;
        logic [WORD_W-1:0] b;
    } arb_cmd_t;

endpackage

// File: rtl/fpu_rr_pick.sv
// Two-way combinational round-robin picker: the pointed requester wins if valid,
// otherwise the other requester wins if valid.
module fpu_rr_pick (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant_c,
    output logic       win_id_c
);

    always_comb begin
        grant_c  = 2'b00;
        win_id_c = ptr;
        if (valid[ptr]) begin
            grant_c[ptr] = 1'b1;
            win_id_c     = ptr;
        end else if (valid[~ptr]) begin
            grant_c[~ptr] = 1'b1;
            win_id_c      = ~ptr;
        end
    end

endmodule

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter/sequencer in front of the shared fpu add/sub unit.
// Optional watchdog enabled by defining FPU_ARB_TIMEOUT_EN.
module fpu_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic                 req0_op,
    input  logic [WORD_W-1:0]    req0_a,
    input  logic [WORD_W-1:0]    req0_b,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic                 req1_op,
    input  logic [WORD_W-1:0]    req1_a,
    input  logic [WORD_W-1:0]    req1_b,
    output logic                 fpu_add,
    output logic                 fpu_sub,
    output logic                 fpu_reg1_s,
    output logic [E_HI-E_LO:0]   fpu_reg1_e,
    output logic [M_HI-M_LO:0]   fpu_reg1_m,
    output logic                 fpu_reg2_s,
    output logic [E_HI-E_LO:0]   fpu_reg2_e,
    output logic [M_HI-M_LO:0]   fpu_reg2_m,
    input  logic                 fpu_res_s,
    input  logic [E_HI-E_LO:0]   fpu_res_e,
    input  logic [M_HI-M_LO:0]   fpu_res_m,
    input  logic                 fpu_idle,
    output logic                 rsp_valid,
    output logic                 rsp_id,
    output logic [WORD_W-1:0]    rsp_data,
    output logic                 rsp_err,
    output logic                 err_flag
);

    logic [2:0]        state_q;
    logic [2:0]        state_d;
    logic              ptr_q;
    logic              id_q;
    logic [WORD_W-1:0] a_q;
    logic [WORD_W-1:0] b_q;
    logic [1:0]        grant_c;
    logic              win_id_c;
    logic              accept_c;
    logic              tmo_c;
    arb_cmd_t          win_cmd_c;

    fpu_rr_pick u_pick (
        .valid    ({req1_valid, req0_valid}),
        .ptr      (ptr_q),
        .grant_c  (grant_c),
        .win_id_c (win_id_c)
    );

    // Arbitrate only while the FPU reports idle and we are not already busy.
    assign accept_c   = (state_q == ST_IDLE) && fpu_idle && (grant_c != 2'b00);
    assign req0_ready = accept_c && grant_c[0];
    assign req1_ready = accept_c && grant_c[1];

    always_comb begin
        win_cmd_c = '0;
        if (win_id_c) begin
            win_cmd_c.op = req1_op;
            win_cmd_c.a  = req1_a;
            win_cmd_c.b  = req1_b;
        end else begin
            win_cmd_c.op = req0_op;
            win_cmd_c.a  = req0_a;
            win_cmd_c.b  = req0_b;
        end
    end

`ifdef FPU_ARB_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt_q;

    // Watchdog counts every cycle spent waiting on the FPU.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q <= '0;
        end else if (state_q == ST_ISSUE) begin
            tmo_cnt_q <= '0;
        end else if ((state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_DONE)) begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
        end
    end

    assign tmo_c = ((state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_DONE)) &&
                   (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    logic [TMO_W-1:0] unused_tmo;
    assign unused_tmo = TMO_W'(TIMEOUT_CYCLES);
    assign tmo_c      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // idle stays high briefly after the start pulse, so completion is only
    // recognised after it has first dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (accept_c) state_d = ST_ISSUE;
            ST_ISSUE:     state_d = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (tmo_c)          state_d = ST_RESP;
                else if (!fpu_idle) state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (tmo_c || fpu_idle) state_d = ST_RESP;
            end
            ST_RESP:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q     <= 1'b0;
            id_q      <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            fpu_add   <= 1'b0;
            fpu_sub   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            err_flag  <= 1'b0;
        end else begin
            fpu_add   <= accept_c && (win_cmd_c.op == OP_ADD);
            fpu_sub   <= accept_c && (win_cmd_c.op == OP_SUB);
            rsp_valid <= (state_d == ST_RESP);
            if (accept_c) begin
                ptr_q <= ~win_id_c;
                id_q  <= win_id_c;
                a_q   <= win_cmd_c.a;
                b_q   <= win_cmd_c.b;
            end
            if (state_d == ST_RESP) begin
                rsp_id   <= id_q;
                rsp_err  <= tmo_c;
                rsp_data <= tmo_c ? WORD_W'(0) : {fpu_res_s, fpu_res_e, fpu_res_m};
            end
            if (tmo_c) begin
                err_flag <= 1'b1;
            end
        end
    end

    assign fpu_reg1_s = a_q[S_BIT];
    assign fpu_reg1_e = a_q[E_HI:E_LO];
    assign fpu_reg1_m = a_q[M_HI:M_LO];
    assign fpu_reg2_s = b_q[S_BIT];
    assign fpu_reg2_e = b_q[E_HI:E_LO];
    assign fpu_reg2_m = b_q[M_HI:M_LO];

endmodule

// File: tb/tb_fpu_arbiter.sv
// Self-checking bench for fpu_arbiter with a fixed-latency FPU stub and a response scoreboard.
// Watchdog expectations follow FPU_ARB_TIMEOUT_EN.
module tb_fpu_arbiter;

    localparam int STUB_HOLD = 2;
    localparam int STUB_LAT  = 5;

    typedef struct {
        logic        op;
        logic [22:0] a;
        logic [22:0] b;
    } req_t;

    typedef struct {
        logic        id;
        logic [22:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic        req0_op = 1'b0, req1_op = 1'b0;
    logic [22:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        fpu_add, fpu_sub;
    logic        fpu_reg1_s, fpu_reg2_s;
    logic [6:0]  fpu_reg1_e, fpu_reg2_e;
    logic [14:0] fpu_reg1_m, fpu_reg2_m;
    logic        fpu_res_s;
    logic [6:0]  fpu_res_e;
    logic [14:0] fpu_res_m;
    logic        fpu_idle = 1'b0;
    logic        rsp_valid, rsp_id, rsp_err, err_flag;
    logic [22:0] rsp_data;

    int errors = 0;
    int checks = 0;

    fpu_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .fpu_add(fpu_add), .fpu_sub(fpu_sub),
        .fpu_reg1_s(fpu_reg1_s), .fpu_reg1_e(fpu_reg1_e), .fpu_reg1_m(fpu_reg1_m),
        .fpu_reg2_s(fpu_reg2_s), .fpu_reg2_e(fpu_reg2_e), .fpu_reg2_m(fpu_reg2_m),
        .fpu_res_s(fpu_res_s), .fpu_res_e(fpu_res_e), .fpu_res_m(fpu_res_m),
        .fpu_idle(fpu_idle),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .err_flag(err_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [22:0] fpu_model(input logic op, input logic [22:0] a, input logic [22:0] b);
        return op ? (a - b) : (a + b);
    endfunction

    // FPU stub: idle held high STUB_HOLD cycles after start, low STUB_LAT cycles, then result.
    int unsigned cyc = 0;
    int unsigned rise_cyc = 0;
    logic        stub_never_drop = 1'b0;
    logic        stub_busy = 1'b0;
    int          stub_cnt = 0;
    int          rst_hold = 0;
    logic        stub_op = 1'b0;
    logic [22:0] stub_a = '0, stub_b = '0, stub_res = '0;
    logic [22:0] cur_a, cur_b;

    assign {fpu_res_s, fpu_res_e, fpu_res_m} = stub_res;
    assign cur_a = {fpu_reg1_s, fpu_reg1_e, fpu_reg1_m};
    assign cur_b = {fpu_reg2_s, fpu_reg2_e, fpu_reg2_m};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            fpu_idle  <= 1'b0;
            rst_hold  <= 2;
            stub_busy <= 1'b0;
            stub_cnt  <= 0;
        end else if (rst_hold != 0) begin
            rst_hold <= rst_hold - 1;
            fpu_idle <= (rst_hold == 1);
        end else if (!stub_busy) begin
            if (fpu_add || fpu_sub) begin
                stub_busy <= 1'b1;
                stub_cnt  <= 0;
                stub_op   <= fpu_sub;
                stub_a    <= cur_a;
                stub_b    <= cur_b;
                stub_res  <= 23'h7fffff;
            end
        end else begin
            stub_cnt <= stub_cnt + 1;
            if (!stub_never_drop) begin
                if (stub_cnt == STUB_HOLD - 1) fpu_idle <= 1'b0;
                if (stub_cnt == STUB_HOLD + STUB_LAT - 1) begin
                    check("opnd_stable", {18'd0, cur_a, cur_b}, {18'd0, stub_a, stub_b});
                    fpu_idle  <= 1'b1;
                    stub_busy <= 1'b0;
                    stub_res  <= fpu_model(stub_op, cur_a, cur_b);
                    rise_cyc  <= cyc + 1;
                end
            end
        end
    end

    // Requester drivers: hold valid and payload until the head request is accepted.
    req_t rq0[$], rq1[$];
    int   rdy0_cnt = 0, rdy1_cnt = 0;
    logic glog[$];

    always @(negedge clk) begin
        req0_valid = (rq0.size() != 0);
        if (rq0.size() != 0) begin
            req0_op = rq0[0].op; req0_a = rq0[0].a; req0_b = rq0[0].b;
        end
        req1_valid = (rq1.size() != 0);
        if (rq1.size() != 0) begin
            req1_op = rq1[0].op; req1_a = rq1[0].a; req1_b = rq1[0].b;
        end
    end

    always @(posedge clk) begin
        if (!reset && req0_ready) begin
            void'(rq0.pop_front()); rdy0_cnt++; glog.push_back(1'b0);
        end
        if (!reset && req1_ready) begin
            void'(rq1.pop_front()); rdy1_cnt++; glog.push_back(1'b1);
        end
    end

    // Output monitor and scoreboard.
    exp_t sb[$];
    int   rsp_cnt = 0, add_pulses = 0, sub_pulses = 0;
    int   add_cyc = 0, wd_lat = 0;
    logic prev_add = 1'b0, prev_sub = 1'b0, prev_rsp = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (prev_add) check("add_width", fpu_add, 1'b0);
        if (prev_sub) check("sub_width", fpu_sub, 1'b0);
        if (prev_rsp) check("rsp_width", rsp_valid, 1'b0);
        if (fpu_add && !prev_add) begin add_pulses++; add_cyc = int'(cyc); end
        if (fpu_sub && !prev_sub) begin sub_pulses++; add_cyc = int'(cyc); end
        if (rsp_valid && !prev_rsp) begin
            rsp_cnt++;
            if (rsp_err) wd_lat = int'(cyc) - add_cyc;
            else begin
                check("idle_to_rsp", cyc - rise_cyc, 1);
                check("rsp_vs_fpu", rsp_data, stub_res);
            end
            if (sb.size() == 0) begin
                check("rsp_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                check("rsp_id", rsp_id, e.id);
                check("rsp_data", rsp_data, e.data);
                check("rsp_err", rsp_err, e.err);
            end
        end
        prev_add = fpu_add; prev_sub = fpu_sub; prev_rsp = rsp_valid;
    end

    task automatic wait_rsps(input int target, input int budget);
        int n = 0;
        while (rsp_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("rsp_timeout", rsp_cnt >= target, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"},
              {fpu_add, fpu_sub, rsp_valid, rsp_id, rsp_err, err_flag, req0_ready, req1_ready}, 0);
        check({tag, "_regs"}, {cur_a, cur_b}, 0);
        check({tag, "_data"}, rsp_data, 0);
    endtask

    task automatic send(input logic id, input logic op, input logic [22:0] a, input logic [22:0] b);
        if (id) rq1.push_back('{op, a, b});
        else    rq0.push_back('{op, a, b});
        sb.push_back('{id, fpu_model(op, a, b), 1'b0});
    endtask

    initial begin
        logic exp_ord [4];
        int   base, r0s, r1s, n;
        exp_ord = '{1'b0, 1'b1, 1'b0, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Single add, requester 0, zero operands
        @(posedge clk);
        send(1'b0, 1'b0, 23'h000000, 23'h000000);
        wait_rsps(1, 100);
        check("single_add_pulses", add_pulses, 1);
        check("single_sub_pulses", sub_pulses, 0);

        // Single sub, requester 1
        repeat (2) @(negedge clk);
        @(posedge clk);
        send(1'b1, 1'b1, 23'h1234ab, 23'h00f00f);
        wait_rsps(2, 100);
        check("single_sub_pulse", sub_pulses, 1);

        // Simultaneous requests alternate 0,1,0,1
        repeat (2) @(negedge clk);
        glog.delete();
        r0s = rdy0_cnt; r1s = rdy1_cnt;
        @(posedge clk);
        rq0.push_back('{1'b0, 23'h0a0b0c, 23'h010203});
        rq0.push_back('{1'b1, 23'h7f0001, 23'h000002});
        rq1.push_back('{1'b0, 23'h111111, 23'h222222});
        rq1.push_back('{1'b1, 23'h400000, 23'h3fffff});
        sb.push_back('{1'b0, fpu_model(1'b0, 23'h0a0b0c, 23'h010203), 1'b0});
        sb.push_back('{1'b1, fpu_model(1'b0, 23'h111111, 23'h222222), 1'b0});
        sb.push_back('{1'b0, fpu_model(1'b1, 23'h7f0001, 23'h000002), 1'b0});
        sb.push_back('{1'b1, fpu_model(1'b1, 23'h400000, 23'h3fffff), 1'b0});
        wait_rsps(6, 200);
        check("grant_count", glog.size(), 4);
        for (int i = 0; i < 4 && i < glog.size(); i++) check("grant_order", glog[i], exp_ord[i]);
        check("ready0_twice", rdy0_cnt - r0s, 2);
        check("ready1_twice", rdy1_cnt - r1s, 2);

        // Lone requester 1 wins twice even though the pointer moves away
        repeat (2) @(negedge clk);
        glog.delete();
        @(posedge clk);
        send(1'b1, 1'b0, 23'h55aa55, 23'h0000ff);
        send(1'b1, 1'b1, 23'h000010, 23'h000020);
        wait_rsps(8, 100);
        check("lone_count", glog.size(), 2);
        for (int i = 0; i < 2 && i < glog.size(); i++) check("lone_order", glog[i], 1'b1);

        // Reset while waiting for completion
        repeat (2) @(negedge clk);
        @(posedge clk);
        rq0.push_back('{1'b0, 23'h123456, 23'h654321});
        n = 0;
        do begin @(negedge clk); n++; end while (fpu_idle && n < 50);
        check("midop_busy", fpu_idle, 1'b0);
        repeat (2) @(negedge clk);
        base = rsp_cnt;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("midop_reset");
        @(posedge clk);
        send(1'b1, 1'b1, 23'h2aaaaa, 23'h155555);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_reset", {req0_ready, req1_ready}, 2'b00);
        check("held_after_reset", rq1.size(), 1);
        wait_rsps(base + 1, 100);
        check("midop_rsp_count", rsp_cnt, base + 1);

        // Watchdog: FPU never drops idle
        repeat (2) @(negedge clk);
        stub_never_drop = 1'b1;
        base = rsp_cnt;
        @(posedge clk);
        rq0.push_back('{1'b0, 23'h000777, 23'h000888});
`ifdef FPU_ARB_TIMEOUT_EN
        sb.push_back('{1'b0, 23'h000000, 1'b1});
        wait_rsps(base + 1, 100);
        check("wd_latency", (wd_lat >= 32 && wd_lat <= 33), 1);
        repeat (5) @(negedge clk);
        check("err_flag_sticky", err_flag, 1'b1);
`else
        n = 0;
        while (rq0.size() != 0 && n < 50) begin @(negedge clk); n++; end
        check("wd_accept", rq0.size(), 0);
        r0s = rdy0_cnt; r1s = rdy1_cnt;
        @(posedge clk);
        rq1.push_back('{1'b1, 23'h000001, 23'h000001});
        repeat (200) @(negedge clk);
        check("no_wd_rsp", rsp_cnt, base);
        check("no_wd_ready0", rdy0_cnt, r0s);
        check("no_wd_ready1", rdy1_cnt, r1s);
        check("no_wd_err", {rsp_err, err_flag}, 2'b00);
`endif
        reset = 1'b1;
        rq0.delete();
        rq1.delete();
        stub_never_drop = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("final_reset");
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpu_arbiter.md
# fpu_arbiter

Two-requester arbiter and sequencer in front of the shared `fpu` add/sub unit. It accepts operation requests over valid/ready handshakes and grants them round-robin. It holds the chosen operands stable on the FPU register inputs, pulses `add`/`sub`, tracks completion through the FPU `idle` output and returns the packed result on a one-cycle response strobe. It sits between the command/program sequencers and the single `fpu` instance; only one operation is in flight at a time.

## Interface
- `TIMEOUT_CYCLES`, default 32: watchdog limit in cycles (used only when `FPU_ARB_TIMEOUT_EN` is defined).
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high; also drives the `fpu` reset.
- `req0_valid`, `req1_valid` in 1: request present; must hold, with payload stable, until ready.
- `req0_ready`, `req1_ready` out 1: request accepted this cycle.
- `req0_op`, `req1_op` in 1: 0 = add, 1 = sub.
- `req0_a`, `req0_b`, `req1_a`, `req1_b` in 23: packed operands {s[22], e[21:15] (two's complement), m[14:0]}.
- `fpu_add`, `fpu_sub` out 1: one-cycle start pulses to the FPU.
- `fpu_reg1_s/e/m`, `fpu_reg2_s/e/m` out 1/7/15: latched operands A and B.
- `fpu_res_s/e/m` in 1/7/15: FPU result.
- `fpu_idle` in 1: FPU idle flag.
- `rsp_valid` out 1: one-cycle result strobe; there is no backpressure.
- `rsp_id` out 1: requester index of the response.
- `rsp_data` out 23: packed result.
- `rsp_err` out 1: watchdog expiry for this response.
- `err_flag` out 1: sticky watchdog flag, cleared only by reset.

## Operation
- **States:** IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- **Reset values:** all outputs 0; state IDLE; round-robin pointer selects requester 0; operand registers 0.
- **IDLE:**
  - Arbitration occurs only when `fpu_idle` = 1.
  - The winner is the pointed requester if its valid is high, else the other requester if its valid is high.
  - `reqN_ready` is asserted combinationally for the winner only.
  - On the accept edge: latch op, a, b and id; move the pointer to the non-winner; go to ISSUE.
- **ISSUE:** assert `fpu_add` (op 0) or `fpu_sub` (op 1) for exactly one cycle, then go to WAIT_BUSY.
- **WAIT_BUSY:** stay until `fpu_idle` = 0, then go to WAIT_DONE. The FPU holds `idle` high for up to two cycles after the start pulse, so `idle` must not be sampled as completion here.
- **WAIT_DONE:** on `fpu_idle` = 1, capture {`fpu_res_s`, `fpu_res_e`, `fpu_res_m`} into `rsp_data`, then go to RESP.
- **RESP:** `rsp_valid` = 1 with `rsp_id`, `rsp_data` and `rsp_err` for one cycle, then go to IDLE. `rsp_data`/`rsp_id` hold their values until the next RESP.
- **Operand stability:** `fpu_reg1_*`/`fpu_reg2_*` change only on an accept edge. The FPU reads them up to the end of its operation.
- **Simultaneous valids:** the pointer decides. Back-to-back requests from both requesters alternate 0, 1, 0, 1.
- **Single requester:** the pointer moving away from it does not block it; it wins again whenever the other requester is idle.
- **Reset mid-operation:**
  - Everything returns to the reset values and no response is emitted.
  - The FPU is reset by the same signal.
  - The first accept waits for `fpu_idle` = 1, which is not guaranteed in the first cycle after reset.

## Timing
- Accept at edge E0 → `fpu_add`/`fpu_sub` high in cycle E0..E1.
- WAIT_BUSY is entered at E1. With the real FPU, `idle` falls at E2, and the arbiter reaches WAIT_DONE at E3.
- `rsp_valid` is high in the cycle after the first `fpu_idle` = 1 sample in WAIT_DONE.
- Next accept is possible at the edge ending the RESP cycle + 1 (IDLE cycle).
- Throughput: one operation per (FPU latency + 4) cycles at most.

## Configuration
- `FPU_ARB_TIMEOUT_EN` defined:
  - A 6-bit counter clears in ISSUE and counts in WAIT_BUSY and WAIT_DONE.
  - Reaching `TIMEOUT_CYCLES` forces RESP with `rsp_err` = 1, `rsp_data` = 0, and sets `err_flag`.
- `FPU_ARB_TIMEOUT_EN` undefined: no counter; `rsp_err` and `err_flag` are tied 0; the arbiter waits indefinitely.

## Structure
- **Package `fpu_arb_pkg`:**
  - state encodings;
  - `OP_ADD` = 0 and `OP_SUB` = 1;
  - word width 23 and field slice constants (S = 22, E = 21:15, M = 14:0);
  - default `TIMEOUT_CYCLES`.
- **Sub-module `fpu_rr_pick`:** two-way combinational round-robin picker. Inputs are the valids and the pointer; outputs are the grant one-hot and the winner id.

## Test plan
- **Single add:** `req0` op 0, a = 23'h000000, b = 23'h000000, real `fpu` → `fpu_add` pulse exactly 1 cycle, `rsp_valid` once, `rsp_id` = 0, `rsp_data` equals the FPU outputs at the `idle` rise, operands unchanged until the response.
- **Simultaneous requests:** both valid continuously for 4 operations → grants in order 0, 1, 0, 1; each `reqN_ready` high exactly twice.
- **Stub FPU, fixed latency:** stub holds `idle` high for 2 cycles after start, then low for 5 → `rsp_valid` exactly 1 cycle after `idle` returns high. No early completion from the initial high `idle`.
- **Reset mid-operation:** `reset` asserted in WAIT_DONE → no `rsp_valid`, all outputs 0; a new request after `fpu_idle` = 1 completes normally with `rsp_id` = requester.
- **Watchdog (macro on):** stub never drops `idle` → `rsp_valid` with `rsp_err` = 1, `rsp_data` = 0, 32 cycles after ISSUE; `err_flag` stays 1 until reset.
- **Watchdog (macro off):** same stub → no `rsp_valid` within 200 cycles; `reqN_ready` stays 0.
